avalon_test_master: RTL and testbench
=====================================

# avalon_test_master

Avalon-MM initiator that exercises the four-register Avalon test responder. On a start pulse it writes a seed-derived pattern to addresses 0–3, then reads each address back, compares the data, and reports pass/fail with a per-address failure mask. It is a bring-up and self-test block: it sits on the initiator side of the same chip-select, active-low strobe, 2-bit address, 32-bit data interface the responder exposes.

## Interface
Parameters:
- READ_LATENCY, default 1: cycles from the read-strobe cycle to valid read data. Legal range 1–3.

Ports:
- iClk  in  1  sole clock; all logic is on the rising edge.
- iReset  in  1  synchronous, active-high reset.
- iStart  in  1  single-cycle request to begin a run; sampled only in IDLE.
- iSeed  in  32  pattern base; sampled on the edge that accepts iStart.
- oChipselect  out  1  bus chip select to the responder.
- oWrite_n  out  1  active-low write strobe.
- oRead_n  out  1  active-low read strobe.
- oAddress  out  2  word address.
- oData  out  32  write data.
- iData  in  32  read data returned by the responder.
- oBusy  out  1  high while a run is in progress.
- oDone  out  1  one-cycle pulse at the end of a run.
- oPass  out  1  1 when the last run had no mismatches.
- oFailMask  out  4  bit k set when address k mismatched in the last run.
- oErrCount  out  3  number of mismatching addresses, 0–4.

## Operation
- Pattern: word k = iSeed rotated left by 8*k bits, for k = 0..3. The seed is latched when iStart is accepted.
- States: IDLE → WRITE → READ → WAIT → (READ | DONE) → IDLE.
- IDLE: bus idle (oChipselect=0, oWrite_n=1, oRead_n=1, oAddress=0, oData=0). When iStart=1, latch the seed, clear oPass, oFailMask and oErrCount, set k=0, and go to WRITE.
- WRITE: one cycle per address with oChipselect=1, oWrite_n=0, oRead_n=1, oAddress=k, oData=word k. After k=3, reset k to 0 and go to READ.
- READ: one cycle with oChipselect=1, oRead_n=0, oWrite_n=1, oAddress=k. Then go to WAIT.
- WAIT: READ_LATENCY cycles with the bus idle. On the edge ending the last WAIT cycle, sample iData and compare it with word k. On mismatch, set oFailMask[k] and increment oErrCount. Then go to READ with k+1, or to DONE if k=3.
- DONE: one cycle with oDone=1 and oPass=(mask==0). Then go to IDLE.
- The write and read strobes are never asserted together. oChipselect is high only in strobe cycles.
- iStart outside IDLE is ignored.
- Results hold until the next accepted iStart.

## Timing
- Reset values: oChipselect=0, oWrite_n=1, oRead_n=1, oAddress=0, oData=0, oBusy=0, oDone=0, oPass=0, oFailMask=0, oErrCount=0. State is IDLE.
- Reset mid-run: the next cycle has the reset values. No oDone is produced and partial results are discarded. The responder's registers are left as they are.
- Cycle numbering: iStart is sampled at edge 0; cycle 1 is the first WRITE cycle.
- Writes occupy cycles 1–4.
- Read k occupies cycle 5+k*(1+READ_LATENCY).
- DONE occurs in cycle 5+4*(1+READ_LATENCY). With READ_LATENCY=1 this is cycle 13; with READ_LATENCY=3 it is cycle 21.
- oBusy is high from cycle 1 through the DONE cycle, inclusive.
- oPass, oFailMask and oErrCount are final when oDone is high.
- A new iStart is accepted on the first IDLE cycle after DONE.

## Structure
- Shared package avalon_test_pkg holds:
  - the state enum (IDLE, WRITE, READ, WAIT, DONE);
  - NUM_WORDS=4 and ADDR_W=2;
  - the pattern function pattern(seed, k) = rotate-left(seed, 8k).
- The package is reused by the responder testbench.
- Single module, no sub-module. The FSM, the k counter and the latency counter are all local.

## Test plan
- Reset: hold iReset for 3 cycles → all outputs at reset values, bus idle, oBusy=0.
- Clean run with READ_LATENCY=1, iSeed=0x12345678, healthy responder:
  - cycles 1–4 write 0x12345678, 0x34567812, 0x56781234, 0x78123456 to addresses 0–3;
  - oDone in cycle 13 with oPass=1, oFailMask=0, oErrCount=0.
- Fault injection: the responder model flips bit 0 on reads of address 2 → oFailMask=4'b0100, oErrCount=1, oPass=0.
- iStart pulsed in cycle 6 → ignored, with exactly one oDone.
  - A second start after DONE with iSeed=0 clears the results.
  - That second run gives oPass=1, since all words are 0.
- Reset asserted during WAIT of address 1 → reset values next cycle, no oDone, and the next run behaves normally.
- READ_LATENCY=3 with a 3-cycle-latency responder model and iSeed=0xA5A5A5A5 → oDone in cycle 21, oPass=1. The bus is idle for 3 cycles after each read strobe.

Source files
------------

// File: rtl/avalon_test_pkg.sv
// Shared types and helpers for the Avalon test initiator and its responder bench.
package avalon_test_pkg;

  localparam int unsigned NUM_WORDS = 4;
  localparam int unsigned ADDR_W    = 2;

  typedef enum logic [2:0] {
    StIdle,
    StWrite,
    StRead,
    StWait,
    StDone
  } state_e;

  // Word k of a run: seed rotated left by 8*k bits.
  function automatic logic [31:0] pattern(input logic [31:0] seed, input logic [ADDR_W-1:0] k);
    logic [63:0] dbl;
    dbl = {seed, seed};
    return dbl[63 - 8 * int'(k) -: 32];
  endfunction

endpackage

// File: rtl/avalon_test_master.sv
// Avalon-MM self-test initiator: writes a seed pattern to four responder registers,
// reads each back after READ_LATENCY cycles and reports a per-address failure mask.
module avalon_test_master
  import avalon_test_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic        iStart,
  input  logic [31:0] iSeed,
  output logic        oChipselect,
  output logic        oWrite_n,
  output logic        oRead_n,
  output logic [1:0]  oAddress,
  output logic [31:0] oData,
  input  logic [31:0] iData,
  output logic        oBusy,
  output logic        oDone,
  output logic        oPass,
  output logic [3:0]  oFailMask,
  output logic [2:0]  oErrCount
);

  localparam logic [ADDR_W-1:0] KLast   = ADDR_W'(NUM_WORDS - 1);
  localparam logic [1:0]        LatLast = 2'(READ_LATENCY - 1);

  state_e                 state_q, state_d;
  logic [ADDR_W-1:0]      k_q, k_d;
  logic [1:0]             lat_q, lat_d;
  logic [31:0]            seed_q, seed_d;
  logic [NUM_WORDS-1:0]   mask_q, mask_d;
  logic [2:0]             err_q, err_d;
  logic                   pass_q, pass_d;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_q <= StIdle;
      k_q     <= '0;
      lat_q   <= '0;
      seed_q  <= '0;
      mask_q  <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      lat_q   <= lat_d;
      seed_q  <= seed_d;
      mask_q  <= mask_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    lat_d   = lat_q;
    seed_d  = seed_q;
    mask_d  = mask_q;
    err_d   = err_q;
    pass_d  = pass_q;
    case (state_q)
      StIdle: begin
        if (iStart) begin
          seed_d  = iSeed;
          mask_d  = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          k_d     = '0;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (k_q == KLast) begin
          k_d     = '0;
          state_d = StRead;
        end else begin
          k_d = k_q + ADDR_W'(1);
        end
      end
      StRead: begin
        lat_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (lat_q == LatLast) begin
          if (iData != pattern(seed_q, k_q)) begin
            mask_d[k_q] = 1'b1;
            err_d       = err_q + 3'd1;
          end
          if (k_q == KLast) begin
            // Pass is resolved here so it is already valid during the Done cycle.
            pass_d  = (mask_d == '0);
            state_d = StDone;
          end else begin
            k_d     = k_q + ADDR_W'(1);
            state_d = StRead;
          end
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    oChipselect = 1'b0;
    oWrite_n    = 1'b1;
    oRead_n     = 1'b1;
    oAddress    = '0;
    oData       = '0;
    case (state_q)
      StWrite: begin
        oChipselect = 1'b1;
        oWrite_n    = 1'b0;
        oAddress    = k_q;
        oData       = pattern(seed_q, k_q);
      end
      StRead: begin
        oChipselect = 1'b1;
        oRead_n     = 1'b0;
        oAddress    = k_q;
      end
      default: ;
    endcase
  end

  assign oBusy     = (state_q != StIdle);
  assign oDone     = (state_q == StDone);
  assign oPass     = pass_q;
  assign oFailMask = mask_q;
  assign oErrCount = err_q;

endmodule

// File: tb/tb_avalon_test_master.sv
// Bench for avalon_test_master: two instances (latency 1 and 3) against responder models.
module tb_avalon_test_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Latency-1 instance
  logic        rst1, start1, cs1, wn1, rn1, busy1, done1, pass1;
  logic [31:0] seed1, dout1, din1;
  logic [1:0]  addr1;
  logic [3:0]  mask1;
  logic [2:0]  err1;
  // Latency-3 instance
  logic        rst3, start3, cs3, wn3, rn3, busy3, done3, pass3;
  logic [31:0] seed3, dout3, din3;
  logic [1:0]  addr3;
  logic [3:0]  mask3;
  logic [2:0]  err3;

  avalon_test_master #(.READ_LATENCY(1)) u_dut1 (
    .iClk(clk), .iReset(rst1), .iStart(start1), .iSeed(seed1),
    .oChipselect(cs1), .oWrite_n(wn1), .oRead_n(rn1), .oAddress(addr1), .oData(dout1),
    .iData(din1), .oBusy(busy1), .oDone(done1), .oPass(pass1), .oFailMask(mask1),
    .oErrCount(err1)
  );

  avalon_test_master #(.READ_LATENCY(3)) u_dut3 (
    .iClk(clk), .iReset(rst3), .iStart(start3), .iSeed(seed3),
    .oChipselect(cs3), .oWrite_n(wn3), .oRead_n(rn3), .oAddress(addr3), .oData(dout3),
    .iData(din3), .oBusy(busy3), .oDone(done3), .oPass(pass3), .oFailMask(mask3),
    .oErrCount(err3)
  );

  // Responder models: four registers, optional single-bit corruption on reads of one address.
  int fault_addr [2] = '{4, 4};
  int fault_bit  [2] = '{0, 0};

  function automatic logic [31:0] fmask(input int s, input logic [1:0] a);
    return (fault_addr[s] == int'(a)) ? (32'b1 << fault_bit[s]) : 32'b0;
  endfunction

  logic [31:0] regs1 [4] = '{default: 32'h0};
  logic [31:0] regs3 [4] = '{default: 32'h0};
  logic        p1_v = 1'b0;
  logic [31:0] p1_d = 32'h0;
  logic [2:0]  p3_v = 3'b000;
  logic [31:0] p3_d [3] = '{default: 32'h0};

  always @(posedge clk) begin
    if (cs1 && !wn1) regs1[addr1] <= dout1;
    p1_v <= cs1 && !rn1;
    p1_d <= regs1[addr1] ^ fmask(0, addr1);
    if (cs3 && !wn3) regs3[addr3] <= dout3;
    p3_v <= {p3_v[1:0], cs3 && !rn3};
    p3_d[0] <= regs3[addr3] ^ fmask(1, addr3);
    p3_d[1] <= p3_d[0];
    p3_d[2] <= p3_d[1];
  end

  // Data outside the valid window is poison, so a mistimed sample shows up as a mismatch.
  assign din1 = p1_v    ? p1_d    : 32'hDEADBEEF;
  assign din3 = p3_v[2] ? p3_d[2] : 32'hDEADBEEF;

  // Probe mux over the instance under test
  logic        sel = 1'b0;
  logic [38:0] p_bus;
  logic [7:0]  p_res;
  assign p_bus = sel ? {cs3, wn3, rn3, addr3, dout3, busy3, done3}
                     : {cs1, wn1, rn1, addr1, dout1, busy1, done1};
  assign p_res = sel ? {pass3, mask3, err3} : {pass1, mask1, err1};

  localparam logic [38:0] BusIdle = {1'b0, 1'b1, 1'b1, 2'b00, 32'h0, 1'b0, 1'b0};

  function automatic logic [31:0] exp_word(input logic [31:0] seed, input int k);
    logic [63:0] t;
    t = {32'h0, seed} << (8 * k);
    return t[31:0] | t[63:32];
  endfunction

  task automatic chk(input string name, input int cyc, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic set_start(input logic v, input logic [31:0] s);
    if (sel) begin start3 = v; seed3 = s; end
    else     begin start1 = v; seed1 = s; end
  endtask

  task automatic set_rst(input logic v);
    if (sel) rst3 = v;
    else     rst1 = v;
  endtask

  // One run from a negedge in IDLE; ends on the negedge of the first IDLE cycle after Done.
  task automatic run(input bit s, input logic [31:0] seed, input int fa, input int fb,
                     input logic [3:0] exp_mask, input int glitch, input int rst_cyc);
    int          lat, done_cyc, rel, dones;
    logic        rd;
    logic [38:0] eb, gb;
    logic [7:0]  exp_res;
    sel = s;
    fault_addr[s] = fa;
    fault_bit[s]  = fb;
    lat      = s ? 3 : 1;
    done_cyc = 5 + 4 * (1 + lat);
    dones    = 0;
    exp_res  = {(exp_mask == 4'b0), exp_mask, 3'($countones(exp_mask))};
    set_start(1'b1, seed);
    @(negedge clk);
    set_start(1'b0, 32'hFFFF_FFFF);
    for (int cyc = 1; cyc <= done_cyc + 1; cyc++) begin
      rd = 1'b0;
      if (cyc <= 4) begin
        eb = {1'b1, 1'b0, 1'b1, 2'(cyc - 1), exp_word(seed, cyc - 1), 1'b1, 1'b0};
      end else if (cyc < done_cyc) begin
        rel = cyc - 5;
        rd  = (rel % (1 + lat)) == 0;
        eb  = rd ? {1'b1, 1'b1, 1'b0, 2'(rel / (1 + lat)), 32'h0, 1'b1, 1'b0}
                 : {1'b0, 1'b1, 1'b1, 2'b00, 32'h0, 1'b1, 1'b0};
      end else if (cyc == done_cyc) begin
        eb = {1'b0, 1'b1, 1'b1, 2'b00, 32'h0, 1'b1, 1'b1};
      end else begin
        eb = BusIdle;
      end
      gb = p_bus;
      if (rd) gb[33:2] = 32'h0;  // write data is unspecified during a read strobe
      chk("bus", cyc, 64'(gb), 64'(eb));
      if (gb[0]) dones++;
      if (cyc == 1) chk("results_cleared", cyc, 64'(p_res), 64'h0);
      if (cyc == done_cyc) chk("results_done", cyc, 64'(p_res), 64'(exp_res));
      if (cyc == done_cyc + 1) begin
        chk("results_hold", cyc, 64'(p_res), 64'(exp_res));
        chk("done_count", cyc, 64'(dones), 64'd1);
      end
      if (cyc == rst_cyc) begin
        set_rst(1'b1);
        @(negedge clk);
        set_rst(1'b0);
        chk("reset_mid_bus", cyc + 1, 64'(p_bus), 64'(BusIdle));
        chk("reset_mid_res", cyc + 1, 64'(p_res), 64'h0);
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          chk("post_reset_idle", cyc + 2 + i, 64'(p_bus), 64'(BusIdle));
        end
        return;
      end
      set_start(cyc == glitch, 32'h5555_AAAA);
      if (cyc != done_cyc + 1) @(negedge clk);
    end
  endtask

  typedef struct {
    bit          s;
    logic [31:0] seed;
    int          fa;
    int          fb;
    int          glitch;
    int          rst_cyc;
    logic [3:0]  exp_mask;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{1'b0, 32'h12345678, 4, 0, -1, -1, 4'b0000};  // clean
    vecs[1] = '{1'b0, 32'h12345678, 2, 0, -1, -1, 4'b0100};  // bit-0 fault on address 2
    vecs[2] = '{1'b0, 32'hDEADBEEF, 2, 0,  6, -1, 4'b0100};  // start in cycle 6 ignored
    vecs[3] = '{1'b0, 32'h00000000, 4, 0, -1, -1, 4'b0000};  // back-to-back restart clears
    vecs[4] = '{1'b0, 32'hCAFEF00D, 4, 0, -1,  8, 4'b0000};  // reset in WAIT of address 1
    vecs[5] = '{1'b0, 32'h0F0F1234, 1, 7, -1, -1, 4'b0010};  // normal after reset
    vecs[6] = '{1'b1, 32'hA5A5A5A5, 4, 0, -1, -1, 4'b0000};  // latency 3
    vecs[7] = '{1'b1, 32'h11223344, 0, 31, -1, -1, 4'b0001};

    rst1 = 1'b1; rst3 = 1'b1;
    start1 = 1'b0; start3 = 1'b0;
    seed1 = 32'h0; seed3 = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("reset_bus", 0, 64'(p_bus), 64'(BusIdle));
      chk("reset_res", 0, 64'(p_res), 64'h0);
    end
    rst1 = 1'b0; rst3 = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run(vecs[i].s, vecs[i].seed, vecs[i].fa, vecs[i].fb, vecs[i].exp_mask,
          vecs[i].glitch, vecs[i].rst_cyc);
    end

    // Random runs; the reference only knows which address the responder corrupts.
    for (int i = 0; i < 12; i++) begin
      bit          s;
      int          fa, fb;
      logic [31:0] seed;
      logic [3:0]  em;
      s    = 1'($urandom_range(0, 1));
      seed = $urandom;
      fa   = int'($urandom_range(0, 4));
      fb   = int'($urandom_range(0, 31));
      em   = (fa < 4) ? 4'(1 << fa) : 4'b0000;
      run(s, seed, fa, fb, em, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
